// File: rtl/arkhe_sched_pkg.sv
// Shared types and opcode constants for the Arkhe gate scheduler.
package arkhe_sched_pkg;

    // Gate opcodes carried in instr_data[31:28]; 9..13 are unassigned and treated as illegal.
    typedef enum logic [3:0] {
        OP_NOP     = 4'd0,
        OP_H       = 4'd1,
        OP_X       = 4'd2,
        OP_Y       = 4'd3,
        OP_Z       = 4'd4,
        OP_S       = 4'd5,
        OP_T       = 4'd6,
        OP_RZ      = 4'd7,
        OP_CX      = 4'd8,
        OP_BARRIER = 4'd14,
        OP_END     = 4'd15
    } gate_op_e;

    // Instruction word layout: {op, tgt, ctl, param}.
    typedef struct packed {
        logic [3:0]  op;
        logic [4:0]  tgt;
        logic [4:0]  ctl;
        logic [17:0] param;
    } gate_word_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        BARRIER = 2'd2,
        DRAIN   = 2'd3
    } sched_state_e;

    // Opcodes 1..7 are single-qubit gates handled by the PE arrays.
    function automatic logic is_single_op(input logic [3:0] op);
        return (op >= OP_H) && (op <= OP_RZ);
    endfunction

endpackage

// File: rtl/arkhe_qubit_scoreboard.sv
// Per-qubit busy mask plus owner registers for each PE and the CX swapper.
// Set requests come from the issue stage; done pulses clear the owner's qubits.
// All updates are registered, so a freed unit/qubit becomes issuable one cycle later.
module arkhe_qubit_scoreboard #(
    parameter int N_QUBITS = 30,
    parameter int N_PE     = 2,
    parameter int QW       = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_PE-1:0]     i_pe_set,
    input  logic [QW-1:0]       i_pe_set_qubit,
    input  logic                i_cx_set,
    input  logic [QW-1:0]       i_cx_set_tgt,
    input  logic [QW-1:0]       i_cx_set_ctl,
    input  logic [N_PE-1:0]     i_pe_done,
    input  logic                i_cx_done,
    input  logic [QW-1:0]       i_chk_tgt,
    input  logic [QW-1:0]       i_chk_ctl,
    output logic [N_QUBITS-1:0] o_busy_mask,
    output logic [N_PE-1:0]     o_pe_busy,
    output logic                o_cx_busy,
    output logic                o_tgt_busy,
    output logic                o_ctl_busy
);

    logic [N_QUBITS-1:0] r_mask;
    logic [N_PE-1:0]     r_pe_busy;
    logic [QW-1:0]       r_pe_owner [N_PE];
    logic                r_cx_busy;
    logic [QW-1:0]       r_cx_tgt;
    logic [QW-1:0]       r_cx_ctl;

    logic [N_PE-1:0]     w_pe_clr;
    logic                w_cx_clr;
    logic [N_QUBITS-1:0] w_set_bits;
    logic [N_QUBITS-1:0] w_clr_bits;
    logic [(1<<QW)-1:0]  w_mask_ext;

    // Done pulses for units that are not busy are spurious and must not clear anything.
    assign w_pe_clr = i_pe_done & r_pe_busy;
    assign w_cx_clr = i_cx_done & r_cx_busy;

    genvar gi, gj;
    generate
        for (gi = 0; gi < N_QUBITS; gi++) begin : g_bit
            logic [N_PE-1:0] w_pe_set_hit;
            logic [N_PE-1:0] w_pe_clr_hit;
            for (gj = 0; gj < N_PE; gj++) begin : g_pe
                assign w_pe_set_hit[gj] = i_pe_set[gj] && (i_pe_set_qubit == QW'(gi));
                assign w_pe_clr_hit[gj] = w_pe_clr[gj] && (r_pe_owner[gj] == QW'(gi));
            end
            assign w_set_bits[gi] = (|w_pe_set_hit) ||
                (i_cx_set && ((i_cx_set_tgt == QW'(gi)) || (i_cx_set_ctl == QW'(gi))));
            assign w_clr_bits[gi] = (|w_pe_clr_hit) ||
                (w_cx_clr && ((r_cx_tgt == QW'(gi)) || (r_cx_ctl == QW'(gi))));
        end
    endgenerate

    // Mask and owner registers; a set only targets free qubits/units, so set and clear never collide.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mask    <= '0;
            r_pe_busy <= '0;
            r_cx_busy <= 1'b0;
            r_cx_tgt  <= '0;
            r_cx_ctl  <= '0;
            for (int i = 0; i < N_PE; i++) begin
                r_pe_owner[i] <= '0;
            end
        end else begin
            r_mask <= (r_mask & ~w_clr_bits) | w_set_bits;
            for (int i = 0; i < N_PE; i++) begin
                if (i_pe_set[i]) begin
                    r_pe_busy[i]  <= 1'b1;
                    r_pe_owner[i] <= i_pe_set_qubit;
                end else if (w_pe_clr[i]) begin
                    r_pe_busy[i]  <= 1'b0;
                end
            end
            if (i_cx_set) begin
                r_cx_busy <= 1'b1;
                r_cx_tgt  <= i_cx_set_tgt;
                r_cx_ctl  <= i_cx_set_ctl;
            end else if (w_cx_clr) begin
                r_cx_busy <= 1'b0;
            end
        end
    end

    // Zero-extend the mask so any QW-bit index is safe; out-of-range indices read as free.
    always_comb begin
        w_mask_ext = '0;
        w_mask_ext[N_QUBITS-1:0] = r_mask;
    end

    assign o_busy_mask = r_mask;
    assign o_pe_busy   = r_pe_busy;
    assign o_cx_busy   = r_cx_busy;
    assign o_tgt_busy  = w_mask_ext[i_chk_tgt];
    assign o_ctl_busy  = w_mask_ext[i_chk_ctl];

endmodule

// File: rtl/arkhe_gate_scheduler.sv
// In-order gate scheduler: decodes gate words, checks qubit/unit hazards and
// dispatches single-qubit gates to the lowest free PE and CX gates to the swapper.
module arkhe_gate_scheduler #(
    parameter int N_QUBITS = 30,
    parameter int N_PE     = 2,
    parameter int QW       = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                instr_valid,
    input  logic [31:0]         instr_data,
    output logic                instr_ready,
    output logic [N_PE-1:0]     pe_gate_valid,
    output logic [N_PE*32-1:0]  pe_gate_op,
    input  logic [N_PE-1:0]     pe_done,
    output logic                cx_start,
    output logic [QW-1:0]       cx_target,
    output logic [QW-1:0]       cx_control,
    input  logic                cx_done,
    output logic [N_QUBITS-1:0] busy_mask,
    output logic                sched_busy,
    output logic                prog_done,
    output logic                illegal_err,
    output logic [31:0]         gate_count
);
    import arkhe_sched_pkg::*;

    localparam logic [QW:0] NQ_LIMIT = (QW+1)'(N_QUBITS);

    sched_state_e         r_state;
    logic [N_PE-1:0]      r_pe_gate_valid;
    logic [N_PE*32-1:0]   r_pe_gate_op;
    logic                 r_cx_start;
    logic [QW-1:0]        r_cx_target;
    logic [QW-1:0]        r_cx_control;
    logic                 r_prog_done;
    logic                 r_illegal_err;
    logic [31:0]          r_gate_count;

    gate_word_t           w_word;
    logic [QW-1:0]        w_tgt;
    logic [QW-1:0]        w_ctl;
    logic                 w_is_single, w_is_cx, w_is_nop, w_is_barrier, w_is_end;
    logic                 w_tgt_ok, w_ctl_ok, w_legal_single, w_legal_cx, w_illegal;
    logic [N_PE-1:0]      w_pe_busy;
    logic                 w_cx_busy, w_tgt_busy, w_ctl_busy;
    logic [N_PE-1:0]      w_pe_sel;
    logic                 w_pe_any_free;
    logic                 w_can_issue;
    logic                 w_accept;
    logic [N_PE-1:0]      w_pe_set;
    logic                 w_cx_set;
    logic                 w_all_free;

    assign w_word = instr_data;
    assign w_tgt  = w_word.tgt;
    assign w_ctl  = w_word.ctl;

    // Qubit range checks apply only to gates; NOP/BARRIER/END ignore their operand fields.
    assign w_is_single    = is_single_op(w_word.op);
    assign w_is_cx        = (w_word.op == OP_CX);
    assign w_is_nop       = (w_word.op == OP_NOP);
    assign w_is_barrier   = (w_word.op == OP_BARRIER);
    assign w_is_end       = (w_word.op == OP_END);
    assign w_tgt_ok       = ({1'b0, w_tgt} < NQ_LIMIT);
    assign w_ctl_ok       = ({1'b0, w_ctl} < NQ_LIMIT) && (w_ctl != w_tgt);
    assign w_legal_single = w_is_single && w_tgt_ok;
    assign w_legal_cx     = w_is_cx && w_tgt_ok && w_ctl_ok;
    assign w_illegal      = !(w_is_nop || w_is_barrier || w_is_end || w_legal_single || w_legal_cx);

    arkhe_qubit_scoreboard #(
        .N_QUBITS (N_QUBITS),
        .N_PE     (N_PE),
        .QW       (QW)
    ) u_scoreboard (
        .clk            (clk),
        .rst            (rst),
        .i_pe_set       (w_pe_set),
        .i_pe_set_qubit (w_tgt),
        .i_cx_set       (w_cx_set),
        .i_cx_set_tgt   (w_tgt),
        .i_cx_set_ctl   (w_ctl),
        .i_pe_done      (pe_done),
        .i_cx_done      (cx_done),
        .i_chk_tgt      (w_tgt),
        .i_chk_ctl      (w_ctl),
        .o_busy_mask    (busy_mask),
        .o_pe_busy      (w_pe_busy),
        .o_cx_busy      (w_cx_busy),
        .o_tgt_busy     (w_tgt_busy),
        .o_ctl_busy     (w_ctl_busy)
    );

    // Lowest-index free PE wins.
    always_comb begin
        w_pe_sel      = '0;
        w_pe_any_free = 1'b0;
        for (int i = 0; i < N_PE; i++) begin
            if (!w_pe_busy[i] && !w_pe_any_free) begin
                w_pe_sel[i]   = 1'b1;
                w_pe_any_free = 1'b1;
            end
        end
    end

    // Hazard check for the head word; non-gate and illegal words never block.
    always_comb begin
        w_can_issue = 1'b1;
        if (w_legal_single) begin
            w_can_issue = !w_tgt_busy && w_pe_any_free;
        end else if (w_legal_cx) begin
            w_can_issue = !w_tgt_busy && !w_ctl_busy && !w_cx_busy;
        end
    end

    assign instr_ready = (r_state == RUN) && w_can_issue;
    assign w_accept    = instr_valid && instr_ready;
    assign w_pe_set    = (w_accept && w_legal_single) ? w_pe_sel : '0;
    assign w_cx_set    = w_accept && w_legal_cx;
    assign w_all_free  = !(|w_pe_busy) && !w_cx_busy;

    // Control FSM and registered dispatch outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= IDLE;
            r_pe_gate_valid <= '0;
            r_pe_gate_op    <= '0;
            r_cx_start      <= 1'b0;
            r_cx_target     <= '0;
            r_cx_control    <= '0;
            r_prog_done     <= 1'b0;
            r_illegal_err   <= 1'b0;
            r_gate_count    <= '0;
        end else begin
            r_pe_gate_valid <= w_pe_set;
            r_cx_start      <= w_cx_set;
            r_prog_done     <= 1'b0;
            for (int i = 0; i < N_PE; i++) begin
                if (w_pe_set[i]) begin
                    r_pe_gate_op[i*32 +: 32] <= w_word;
                end
            end
            if (w_cx_set) begin
                r_cx_target  <= w_tgt;
                r_cx_control <= w_ctl;
            end
            if ((|w_pe_set) || w_cx_set) begin
                r_gate_count <= r_gate_count + 32'd1;
            end
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state       <= RUN;
                        r_gate_count  <= '0;
                        r_illegal_err <= 1'b0;
                    end
                end
                RUN: begin
                    if (w_accept) begin
                        if (w_illegal) begin
                            r_illegal_err <= 1'b1;
                        end
                        if (w_is_barrier) begin
                            r_state <= BARRIER;
                        end else if (w_is_end) begin
                            // Nothing in flight: DRAIN would exit immediately, so finish now.
                            if (w_all_free) begin
                                r_state     <= IDLE;
                                r_prog_done <= 1'b1;
                            end else begin
                                r_state <= DRAIN;
                            end
                        end
                    end
                end
                BARRIER: begin
                    if (w_all_free) begin
                        r_state <= RUN;
                    end
                end
                DRAIN: begin
                    if (w_all_free) begin
                        r_state     <= IDLE;
                        r_prog_done <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign pe_gate_valid = r_pe_gate_valid;
    assign pe_gate_op    = r_pe_gate_op;
    assign cx_start      = r_cx_start;
    assign cx_target     = r_cx_target;
    assign cx_control    = r_cx_control;
    assign sched_busy    = (r_state != IDLE);
    assign prog_done     = r_prog_done;
    assign illegal_err   = r_illegal_err;
    assign gate_count    = r_gate_count;

endmodule

// File: tb/tb_arkhe_gate_scheduler.sv
// Scenario bench for arkhe_gate_scheduler with a dispatch scoreboard queue.
module tb_arkhe_gate_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        instr_valid;
    logic [31:0] instr_data;
    logic        instr_ready;
    logic [1:0]  pe_gate_valid;
    logic [63:0] pe_gate_op;
    logic [1:0]  pe_done;
    logic        cx_start;
    logic [4:0]  cx_target;
    logic [4:0]  cx_control;
    logic        cx_done;
    logic [29:0] busy_mask;
    logic        sched_busy;
    logic        prog_done;
    logic        illegal_err;
    logic [31:0] gate_count;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    typedef struct {
        bit          is_cx;
        int          pe;
        logic [31:0] word;
        int          cyc;
    } exp_t;
    exp_t exp_q[$];

    localparam logic [31:0] W_H3   = 32'h1180_0000;
    localparam logic [31:0] W_X3   = 32'h2180_0000;
    localparam logic [31:0] W_H0   = 32'h1000_0000;
    localparam logic [31:0] W_H1   = 32'h1080_0000;
    localparam logic [31:0] W_H2   = 32'h1100_0000;
    localparam logic [31:0] W_X2   = 32'h2100_0000;
    localparam logic [31:0] W_CX57 = 32'h8394_0000;
    localparam logic [31:0] W_OP9  = 32'h9000_0000;
    localparam logic [31:0] W_T30  = 32'h1F00_0000;
    localparam logic [31:0] W_CX44 = 32'h8210_0000;
    localparam logic [31:0] W_NOP  = 32'h0000_0000;
    localparam logic [31:0] W_BAR  = 32'hE000_0000;
    localparam logic [31:0] W_END  = 32'hF000_0000;

    arkhe_gate_scheduler dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .instr_valid   (instr_valid),
        .instr_data    (instr_data),
        .instr_ready   (instr_ready),
        .pe_gate_valid (pe_gate_valid),
        .pe_gate_op    (pe_gate_op),
        .pe_done       (pe_done),
        .cx_start      (cx_start),
        .cx_target     (cx_target),
        .cx_control    (cx_control),
        .cx_done       (cx_done),
        .busy_mask     (busy_mask),
        .sched_busy    (sched_busy),
        .prog_done     (prog_done),
        .illegal_err   (illegal_err),
        .gate_count    (gate_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Dispatch monitor: every pulse must match the oldest expected dispatch, one cycle after accept.
    always @(negedge clk) begin
        int   n;
        bit   ok;
        exp_t e;
        n = 0;
        for (int i = 0; i < 2; i++) if (pe_gate_valid[i] === 1'b1) n++;
        if (cx_start === 1'b1) n++;
        if (n > 1) begin
            checks++; errors++;
            $display("FAIL dispatch_multi cyc=%0d pe_gate_valid=%b cx_start=%b", cyc, pe_gate_valid, cx_start);
        end else if (n == 1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL dispatch_unexpected cyc=%0d pe_gate_valid=%b cx_start=%b", cyc, pe_gate_valid, cx_start);
            end else begin
                e = exp_q.pop_front();
                if (e.is_cx)
                    ok = (cx_start === 1'b1) && (cx_target === e.word[27:23]) && (cx_control === e.word[22:18]);
                else
                    ok = (pe_gate_valid[e.pe] === 1'b1) && (pe_gate_op[e.pe*32 +: 32] === e.word);
                ok = ok && (cyc == e.cyc);
                if (!ok)
                    $display("FAIL dispatch cyc=%0d valid=%b op=%h cx=%b tgt=%0d ctl=%0d need cx=%0d pe=%0d word=%h cyc=%0d",
                             cyc, pe_gate_valid, pe_gate_op, cx_start, cx_target, cx_control, e.is_cx, e.pe, e.word, e.cyc);
                if (!ok) errors++;
            end
        end
    end

    task automatic align();
        @(posedge clk);
        #1;
    endtask

    // Present a word until accepted (bounded); acc is the accept cycle or -1 on timeout.
    task automatic send(input logic [31:0] w, input bit is_cx, input int pe, input bit disp, output int acc);
        acc = -1;
        instr_valid = 1'b1;
        instr_data  = w;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (instr_ready === 1'b1) begin
                acc = cyc;
                if (disp) exp_q.push_back('{is_cx, pe, w, cyc + 1});
                break;
            end
        end
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        instr_data  = '0;
    endtask

    task automatic pulse(input logic [1:0] pe, input logic cx);
        pe_done = pe;
        cx_done = cx;
        align();
        pe_done = 2'b00;
        cx_done = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        align();
        start = 1'b0;
    endtask

    task automatic restart();
        int e;
        send(W_END, 0, 0, 0, e);
        do_start();
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if ({pe_gate_valid, cx_start, busy_mask, sched_busy, prog_done, illegal_err, instr_ready} !== '0 || gate_count !== 32'd0) begin
            errors++;
            $display("FAIL reset_state valid=%b cx=%b mask=%h busy=%b done=%b ill=%b rdy=%b gc=%0d need all 0",
                     pe_gate_valid, cx_start, busy_mask, sched_busy, prog_done, illegal_err, instr_ready, gate_count);
        end
        align();
    endtask

    task automatic test_single_dep();
        int a, b, d;
        do_start();
        send(W_H3, 0, 0, 1, a);
        @(negedge clk);
        checks++;
        if (a < 0 || busy_mask !== 30'h8 || gate_count !== 32'd1 || pe_gate_valid !== 2'b01) begin
            errors++;
            $display("FAIL single_first acc=%0d mask=%h gc=%0d valid=%b need mask=8 gc=1 valid=01", a, busy_mask, gate_count, pe_gate_valid);
        end
        align();
        fork
            send(W_X3, 0, 0, 1, b);
            begin repeat (3) align(); d = cyc; pulse(2'b01, 1'b0); end
        join
        checks++;
        if (b !== d + 1) begin
            errors++;
            $display("FAIL single_dep_accept acc=%0d need %0d", b, d + 1);
        end
        @(negedge clk);
        checks++;
        if (busy_mask !== 30'h8 || gate_count !== 32'd2) begin
            errors++;
            $display("FAIL single_second mask=%h gc=%0d need 8/2", busy_mask, gate_count);
        end
        align();
        pulse(2'b01, 1'b0);
        @(negedge clk);
        checks++;
        if (busy_mask !== 30'h0) begin
            errors++;
            $display("FAIL single_free mask=%h need 0", busy_mask);
        end
        align();
    endtask

    task automatic test_back_to_back();
        int a, b, c, d;
        restart();
        send(W_H0, 0, 0, 1, a);
        send(W_H1, 0, 1, 1, b);
        checks++;
        if (a < 0 || b !== a + 1) begin
            errors++;
            $display("FAIL b2b_accept acc0=%0d acc1=%0d need consecutive", a, b);
        end
        fork
            send(W_H2, 0, 0, 1, c);
            begin repeat (4) align(); d = cyc; pulse(2'b01, 1'b0); end
        join
        checks++;
        if (c !== d + 1) begin
            errors++;
            $display("FAIL b2b_stall acc=%0d need %0d", c, d + 1);
        end
        @(negedge clk);
        checks++;
        if (gate_count !== 32'd3 || busy_mask !== 30'h6) begin
            errors++;
            $display("FAIL b2b_count gc=%0d mask=%h need 3/6", gate_count, busy_mask);
        end
        align();
        pulse(2'b11, 1'b0);
        @(negedge clk);
        checks++;
        if (busy_mask !== 30'h0) begin
            errors++;
            $display("FAIL b2b_dual_done mask=%h need 0", busy_mask);
        end
        align();
        pulse(2'b10, 1'b1);
        @(negedge clk);
        checks++;
        if (busy_mask !== 30'h0 || gate_count !== 32'd3) begin
            errors++;
            $display("FAIL spurious_done mask=%h gc=%0d need 0/3", busy_mask, gate_count);
        end
        align();
    endtask

    task automatic test_cx();
        int a, b, d;
        send(W_CX57, 1, 0, 1, a);
        @(negedge clk);
        checks++;
        if (cx_start !== 1'b1 || cx_target !== 5'd7 || cx_control !== 5'd5 || busy_mask !== 30'hA0) begin
            errors++;
            $display("FAIL cx_dispatch start=%b tgt=%0d ctl=%0d mask=%h need 1/7/5/a0", cx_start, cx_target, cx_control, busy_mask);
        end
        align();
        fork
            send(W_CX57, 1, 0, 1, b);
            begin repeat (3) align(); d = cyc; pulse(2'b00, 1'b1); end
        join
        checks++;
        if (b !== d + 1) begin
            errors++;
            $display("FAIL cx_reissue acc=%0d need %0d", b, d + 1);
        end
        @(negedge clk);
        checks++;
        if (busy_mask !== 30'hA0 || gate_count !== 32'd5) begin
            errors++;
            $display("FAIL cx_second mask=%h gc=%0d need a0/5", busy_mask, gate_count);
        end
        align();
        pulse(2'b00, 1'b1);
        @(negedge clk);
        checks++;
        if (busy_mask !== 30'h0) begin
            errors++;
            $display("FAIL cx_free mask=%h need 0", busy_mask);
        end
        align();
    endtask

    task automatic test_illegal();
        logic [31:0] words [3];
        int a, c0;
        words[0] = W_OP9; words[1] = W_T30; words[2] = W_CX44;
        checks++;
        if (illegal_err !== 1'b0) begin
            errors++;
            $display("FAIL illegal_pre err=%b need 0", illegal_err);
        end
        for (int i = 0; i < 3; i++) begin
            c0 = cyc;
            send(words[i], 0, 0, 0, a);
            checks++;
            if (a !== c0) begin
                errors++;
                $display("FAIL illegal_accept word=%h acc=%0d need %0d", words[i], a, c0);
            end
        end
        send(W_NOP, 0, 0, 0, a);
        @(negedge clk);
        checks++;
        if (illegal_err !== 1'b1 || busy_mask !== 30'h0 || gate_count !== 32'd5) begin
            errors++;
            $display("FAIL illegal_sticky err=%b mask=%h gc=%0d need 1/0/5", illegal_err, busy_mask, gate_count);
        end
        align();
        restart();
        @(negedge clk);
        checks++;
        if (illegal_err !== 1'b0 || gate_count !== 32'd0 || sched_busy !== 1'b1) begin
            errors++;
            $display("FAIL illegal_clear err=%b gc=%0d busy=%b need 0/0/1", illegal_err, gate_count, sched_busy);
        end
        align();
    endtask

    task automatic test_barrier_end();
        int a, b, c, d, e;
        bit seen;
        send(W_H1, 0, 0, 1, a);
        send(W_BAR, 0, 0, 0, b);
        @(negedge clk);
        checks++;
        if (b !== a + 1 || instr_ready !== 1'b0 || sched_busy !== 1'b1) begin
            errors++;
            $display("FAIL barrier_enter acc=%0d rdy=%b busy=%b need %0d/0/1", b, instr_ready, sched_busy, a + 1);
        end
        align();
        fork
            send(W_X2, 0, 0, 1, c);
            begin repeat (10) align(); d = cyc; pulse(2'b01, 1'b0); end
        join
        checks++;
        if (c !== d + 2) begin
            errors++;
            $display("FAIL barrier_hold acc=%0d need %0d", c, d + 2);
        end
        @(negedge clk);
        checks++;
        if (busy_mask !== 30'h4) begin
            errors++;
            $display("FAIL barrier_after mask=%h need 4", busy_mask);
        end
        align();
        pulse(2'b01, 1'b0);
        send(W_END, 0, 0, 0, e);
        @(negedge clk);
        checks++;
        if (e < 0 || prog_done !== 1'b1 || sched_busy !== 1'b0) begin
            errors++;
            $display("FAIL end_idle acc=%0d done=%b busy=%b need 1/0", e, prog_done, sched_busy);
        end
        align();
        @(negedge clk);
        checks++;
        if (prog_done !== 1'b0) begin
            errors++;
            $display("FAIL end_pulse done=%b need 0", prog_done);
        end
        align();
        do_start();
        send(W_H0, 0, 0, 1, a);
        send(W_END, 0, 0, 0, e);
        @(negedge clk);
        checks++;
        if (sched_busy !== 1'b1 || prog_done !== 1'b0) begin
            errors++;
            $display("FAIL drain_wait busy=%b done=%b need 1/0", sched_busy, prog_done);
        end
        align();
        repeat (3) align();
        pulse(2'b01, 1'b0);
        seen = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (prog_done === 1'b1) begin seen = 1'b1; break; end
        end
        checks++;
        if (seen !== 1'b1 || sched_busy !== 1'b0) begin
            errors++;
            $display("FAIL drain_done seen=%b busy=%b need 1/0", seen, sched_busy);
        end
        align();
    endtask

    task automatic test_reset_busy();
        int a, b, c;
        do_start();
        send(W_H0, 0, 0, 1, a);
        send(W_CX57, 1, 0, 1, b);
        @(negedge clk);
        checks++;
        if (busy_mask !== 30'hA1) begin
            errors++;
            $display("FAIL rst_pre mask=%h need a1", busy_mask);
        end
        align();
        rst = 1'b1;
        align();
        align();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({pe_gate_valid, pe_gate_op, cx_start, cx_target, cx_control, busy_mask, sched_busy, prog_done, illegal_err, instr_ready} !== '0
            || gate_count !== 32'd0) begin
            errors++;
            $display("FAIL rst_outputs valid=%b cx=%b tgt=%0d ctl=%0d mask=%h busy=%b gc=%0d need all 0",
                     pe_gate_valid, cx_start, cx_target, cx_control, busy_mask, sched_busy, gate_count);
        end
        align();
        pulse(2'b01, 1'b1);
        @(negedge clk);
        checks++;
        if (busy_mask !== 30'h0 || sched_busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_stale_done mask=%h busy=%b need 0/0", busy_mask, sched_busy);
        end
        align();
        do_start();
        send(W_H3, 0, 0, 1, c);
        @(negedge clk);
        checks++;
        if (c < 0 || gate_count !== 32'd1 || busy_mask !== 30'h8 || sched_busy !== 1'b1) begin
            errors++;
            $display("FAIL rst_restart acc=%0d gc=%0d mask=%h busy=%b need 1/8/1", c, gate_count, busy_mask, sched_busy);
        end
        align();
        pulse(2'b01, 1'b0);
        send(W_END, 0, 0, 0, c);
    endtask

    initial begin
        rst         = 1'b1;
        start       = 1'b0;
        instr_valid = 1'b0;
        instr_data  = '0;
        pe_done     = 2'b00;
        cx_done     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        test_reset();
        test_single_dep();
        test_back_to_back();
        test_cx();
        test_illegal();
        test_barrier_end();
        test_reset_busy();
        repeat (3) align();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL dispatch_missing outstanding=%0d need 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
